// File: rtl/adc_acq_scheduler.sv
// Arbitrates one SAR ADC between the EMG and BioZ sequencers: EMG priority with a
// BioZ starvation guard, and EMG requests are blanked around stimulation pulses.
module adc_acq_scheduler #(
    parameter int CONV_CYCLES  = 13,
    parameter int BLANK_TAIL   = 20,
    parameter int STARVE_LIMIT = 64
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       ENABLE,
    input  logic       CAT_ST,
    input  logic       ANO_ST,
    input  logic       DIS_ST,
    input  logic       EMG_REQ,
    input  logic       BIOZ_REQ,
    output logic       ADC_START,
    output logic       ADC_SRC,
    output logic       ADC_BUSY,
    output logic       EMG_VALID,
    output logic       BIOZ_VALID,
    output logic       EMG_TAINT,
    output logic       BLANK,
    output logic       EMG_DROP,
    output logic       REQ_OVERRUN,
    output logic [7:0] EMG_DROP_CNT
);
    localparam int CNT_W  = $clog2(CONV_CYCLES);
    localparam int TAIL_W = $clog2(BLANK_TAIL + 1);
    localparam logic [7:0] STARVE_L = 8'(STARVE_LIMIT);

    typedef enum logic {IDLE, CONV} state_t;

    state_t            state;
    logic [CNT_W-1:0]  conv_cnt;
    logic [TAIL_W-1:0] tail_cnt;
    logic              emg_pend;
    logic              bioz_pend;
    logic              taint;
    logic [7:0]        bioz_wait;

    logic stim_any, blank_now, emg_drop_now, emg_ok, bioz_ok;
    logic emg_eff, bioz_eff, can_grant, pick_bioz, grant_emg, grant_bioz;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    assign stim_any     = CAT_ST | ANO_ST | DIS_ST;
    assign blank_now    = stim_any | (tail_cnt != '0);
    assign emg_drop_now = EMG_REQ & blank_now;
    assign emg_ok       = EMG_REQ & ENABLE & ~blank_now;
    assign bioz_ok      = BIOZ_REQ & ENABLE;

    // A request arriving at the grant edge competes immediately, giving one-cycle latency.
    assign emg_eff    = (emg_pend & ~emg_drop_now) | emg_ok;
    assign bioz_eff   = bioz_pend | bioz_ok;
    assign can_grant  = (state == IDLE) & ENABLE & (emg_eff | bioz_eff);
    assign pick_bioz  = bioz_eff & ~(emg_eff & (bioz_wait < STARVE_L));
    assign grant_emg  = can_grant & ~pick_bioz;
    assign grant_bioz = can_grant & pick_bioz;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state        <= IDLE;
            conv_cnt     <= '0;
            tail_cnt     <= '0;
            emg_pend     <= 1'b0;
            bioz_pend    <= 1'b0;
            taint        <= 1'b0;
            bioz_wait    <= '0;
            ADC_START    <= 1'b0;
            ADC_SRC      <= 1'b0;
            ADC_BUSY     <= 1'b0;
            EMG_VALID    <= 1'b0;
            BIOZ_VALID   <= 1'b0;
            EMG_TAINT    <= 1'b0;
            BLANK        <= 1'b0;
            EMG_DROP     <= 1'b0;
            REQ_OVERRUN  <= 1'b0;
            EMG_DROP_CNT <= '0;
        end else begin
            if (stim_any)
                tail_cnt <= TAIL_W'(BLANK_TAIL);
            else if (tail_cnt != '0)
                tail_cnt <= tail_cnt - TAIL_W'(1);
            BLANK    <= blank_now;
            EMG_DROP <= emg_drop_now;
            if (emg_drop_now)
                EMG_DROP_CNT <= sat_inc8(EMG_DROP_CNT);
            REQ_OVERRUN <= (emg_ok & emg_pend & ~grant_emg) | (bioz_ok & bioz_pend & ~grant_bioz);

            // A granted source keeps its flag only if a fresh request lands on top of an old one.
            if (!ENABLE) begin
                emg_pend  <= 1'b0;
                bioz_pend <= 1'b0;
                bioz_wait <= '0;
            end else begin
                emg_pend  <= grant_emg ? (emg_pend & emg_ok) : emg_eff;
                bioz_pend <= grant_bioz ? (bioz_pend & bioz_ok) : bioz_eff;
                if (grant_bioz)
                    bioz_wait <= '0;
                else if (bioz_pend)
                    bioz_wait <= sat_inc8(bioz_wait);
            end

            ADC_START  <= 1'b0;
            EMG_VALID  <= 1'b0;
            BIOZ_VALID <= 1'b0;
            EMG_TAINT  <= 1'b0;
            case (state)
                IDLE: begin
                    if (can_grant) begin
                        state     <= CONV;
                        ADC_START <= 1'b1;
                        ADC_BUSY  <= 1'b1;
                        ADC_SRC   <= grant_bioz;
                        conv_cnt  <= CNT_W'(CONV_CYCLES - 1);
                        taint     <= 1'b0;
                    end
                end
                CONV: begin
                    if (stim_any && !ADC_SRC)
                        taint <= 1'b1;
                    if (conv_cnt == '0) begin
                        state      <= IDLE;
                        ADC_BUSY   <= 1'b0;
                        EMG_VALID  <= ~ADC_SRC;
                        BIOZ_VALID <= ADC_SRC;
                        EMG_TAINT  <= ~ADC_SRC & (taint | stim_any);
                    end else begin
                        conv_cnt <= conv_cnt - CNT_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_adc_acq_scheduler.sv
// Bench for adc_acq_scheduler: directed scenarios plus random traffic against a
// cycle-number based reference model (blank window, conversion interval, request counts).
module tb_adc_acq_scheduler;
    localparam int CONV   = 13;
    localparam int TAIL   = 20;
    localparam int STARVE = 64;

    logic clk = 1'b0;
    logic rst, en, cat, ano, dis, ereq, breq;
    logic start, src, busy, ev, bv, taint, blank, edrop, ovr;
    logic [7:0] dcnt;

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // Reference model: times of last stimulation and of the current conversion start,
    // plus outstanding request counts per source.
    int last_stim = -1000;
    int cs        = -1000;
    int e_out     = 0;
    int b_out     = 0;
    int mwait     = 0;
    int mdcnt     = 0;
    bit csrc      = 1'b0;
    bit ctaint    = 1'b0;
    bit x_start   = 1'b0;
    bit x_blank   = 1'b0;
    bit x_drop    = 1'b0;
    bit x_ovr     = 1'b0;

    always #5 clk = ~clk;

    adc_acq_scheduler #(
        .CONV_CYCLES (CONV),
        .BLANK_TAIL  (TAIL),
        .STARVE_LIMIT(STARVE)
    ) dut (
        .CLK         (clk),
        .RESET       (rst),
        .ENABLE      (en),
        .CAT_ST      (cat),
        .ANO_ST      (ano),
        .DIS_ST      (dis),
        .EMG_REQ     (ereq),
        .BIOZ_REQ    (breq),
        .ADC_START   (start),
        .ADC_SRC     (src),
        .ADC_BUSY    (busy),
        .EMG_VALID   (ev),
        .BIOZ_VALID  (bv),
        .EMG_TAINT   (taint),
        .BLANK       (blank),
        .EMG_DROP    (edrop),
        .REQ_OVERRUN (ovr),
        .EMG_DROP_CNT(dcnt)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Apply the current inputs to the model, clock once, then compare every output.
    task automatic tick();
        bit stim, blk, busy_now, e_drop, e_new, b_new, ge, gb, xb, xev, xbv;
        int b_old;
        logic [8:0] exp_v, obs_v;
        if (rst) begin
            last_stim = -1000; cs = -1000; csrc = 0; ctaint = 0;
            e_out = 0; b_out = 0; mwait = 0; mdcnt = 0;
            x_start = 0; x_blank = 0; x_drop = 0; x_ovr = 0;
        end else begin
            stim = cat | ano | dis;
            if (stim) last_stim = cyc;
            blk      = (cyc - last_stim) <= TAIL;
            busy_now = (cyc >= cs) && (cyc < cs + CONV);
            if (busy_now && !csrc && stim) ctaint = 1;
            e_drop = ereq && blk;
            e_new  = ereq && en && !blk;
            b_new  = breq && en;
            b_old  = b_out;
            if (e_drop) begin
                e_out = 0;
                if (mdcnt < 255) mdcnt++;
            end
            e_out += int'(e_new);
            b_out += int'(b_new);
            ge = 0; gb = 0;
            if (en && !busy_now && (e_out > 0 || b_out > 0)) begin
                if (e_out > 0 && mwait < STARVE) ge = 1;
                else if (b_out > 0)              gb = 1;
                else                             ge = 1;
            end
            if (ge) e_out--;
            if (gb) b_out--;
            x_ovr = (e_out > 1) || (b_out > 1);
            if (e_out > 1) e_out = 1;
            if (b_out > 1) b_out = 1;
            if (!en) begin
                e_out = 0; b_out = 0; mwait = 0;
            end else if (gb) begin
                mwait = 0;
            end else if (b_old > 0 && mwait < 255) begin
                mwait++;
            end
            if (ge || gb) begin
                cs = cyc + 1; csrc = gb; ctaint = 0;
            end
            x_start = ge || gb;
            x_blank = blk;
            x_drop  = e_drop;
        end
        @(posedge clk);
        #1;
        cyc++;
        xb  = (cyc >= cs) && (cyc < cs + CONV);
        xev = (cyc == cs + CONV) && !csrc;
        xbv = (cyc == cs + CONV) && csrc;
        exp_v = {x_start, csrc, xb, xev, xbv, xev && ctaint, x_blank, x_drop, x_ovr};
        obs_v = {start, src, busy, ev, bv, taint, blank, edrop, ovr};
        check("outputs", 32'(obs_v), 32'(exp_v));
        check("drop_cnt", 32'(dcnt), 32'(mdcnt));
    endtask

    initial begin
        int k, starts, hits, d0, stim_left, ph;
        bit found;
        stim_left = 0; ph = 0;
        rst = 1; en = 0; cat = 0; ano = 0; dis = 0; ereq = 0; breq = 0;
        tick();
        tick();
        check("reset_outs", 32'({start, src, busy, ev, bv, taint, blank, edrop, ovr}), 32'(0));
        check("reset_cnt", 32'(dcnt), 32'(0));
        rst = 0; en = 1;
        repeat (8) tick();

        // single EMG request
        ereq = 1; tick(); ereq = 0;
        check("single_start", 32'({start, src, busy}), 32'(3'b101));
        repeat (12) tick();
        check("single_busy_end", 32'({busy, ev}), 32'(2'b10));
        tick();
        check("single_valid", 32'({busy, ev, taint, bv}), 32'(4'b0100));
        repeat (4) tick();

        // simultaneous EMG and BioZ
        ereq = 1; breq = 1; tick(); ereq = 0; breq = 0;
        check("both_first_src", 32'({start, src}), 32'(2'b10));
        found = 0; k = 0;
        while (!found && k < 40) begin tick(); k++; if (start) found = 1; end
        check("both_gap", 32'(k), 32'(14));
        check("both_second_src", 32'(src), 32'(1));
        repeat (13) tick();
        check("bioz_valid", 32'({bv, ev}), 32'(2'b10));
        repeat (4) tick();

        // BioZ starvation guard under continuous EMG demand
        ereq = 1; breq = 1; tick(); breq = 0;
        check("starve_first_emg", 32'({start, src}), 32'(2'b10));
        found = 0; k = 0; starts = 0;
        while (!found && k < 200) begin
            tick(); k++;
            if (start && src) found = 1;
            else if (start) starts++;
        end
        check("starve_gap", 32'(k), 32'(70));
        check("starve_emg_grants", 32'(starts), 32'(4));
        found = 0; k = 0;
        while (!found && k < 40) begin tick(); k++; if (start) found = 1; end
        check("post_starve_gap", 32'(k), 32'(14));
        check("post_starve_src", 32'(src), 32'(0));
        ereq = 0;
        repeat (40) tick();

        // 150-cycle CAT pulse with EMG requests every 5 cycles
        d0 = int'(dcnt); hits = 0;
        for (int off = 0; off <= 170; off++) begin
            cat  = (off < 150);
            ereq = (off % 5 == 0);
            tick();
            if (edrop) hits++;
            if (off == 169) check("blank_tail_high", 32'(blank), 32'(1));
        end
        cat = 0; ereq = 0;
        check("blank_fall", 32'(blank), 32'(0));
        check("post_blank_start", 32'({start, src}), 32'(2'b10));
        check("blank_drop_pulses", 32'(hits), 32'(34));
        check("blank_drop_cnt", 32'(int'(dcnt) - d0), 32'(34));
        repeat (15) tick();

        // DIS pulse during an EMG conversion
        ereq = 1; tick(); ereq = 0;
        check("taint_start", 32'({start, src}), 32'(2'b10));
        repeat (4) tick();
        dis = 1; tick(); dis = 0;
        found = 0; k = 0;
        while (!found && k < 20) begin tick(); k++; if (ev) found = 1; end
        check("taint_valid_seen", 32'(found), 32'(1));
        check("taint_flag", 32'(taint), 32'(1));
        repeat (25) tick();

        // 300 blanked requests saturate the drop counter
        cat = 1; ereq = 1;
        repeat (300) tick();
        check("drop_sat", 32'(dcnt), 32'(255));
        cat = 0; ereq = 0;
        repeat (25) tick();

        // requests while disabled are neither pended nor granted
        en = 0; ereq = 1; breq = 1; tick(); ereq = 0; breq = 0;
        starts = start ? 1 : 0;
        repeat (2) begin tick(); if (start) starts++; end
        en = 1;
        repeat (3) begin tick(); if (start) starts++; end
        check("en0_no_grant", 32'(starts), 32'(0));

        // reset in the middle of a conversion
        ereq = 1; tick(); ereq = 0;
        repeat (5) tick();
        check("mid_busy", 32'(busy), 32'(1));
        rst = 1; tick(); rst = 0;
        check("reset_mid_outs", 32'({start, src, busy, ev, bv, taint, blank, edrop, ovr}), 32'(0));
        check("reset_mid_cnt", 32'(dcnt), 32'(0));
        hits = 0;
        repeat (20) begin tick(); if (ev || bv) hits++; end
        check("reset_mid_no_valid", 32'(hits), 32'(0));

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            rst = ($urandom_range(0, 599) == 0);
            en  = ($urandom_range(0, 39) != 0);
            if (stim_left > 0) stim_left--;
            else if ($urandom_range(0, 149) == 0) begin
                stim_left = int'($urandom_range(1, 30));
                ph        = int'($urandom_range(0, 2));
            end
            cat  = (stim_left > 0) && (ph == 0);
            ano  = (stim_left > 0) && (ph == 1);
            dis  = (stim_left > 0) && (ph == 2);
            ereq = ($urandom_range(0, 5) == 0);
            breq = ($urandom_range(0, 9) == 0);
            tick();
        end
        rst = 0; cat = 0; ano = 0; dis = 0; ereq = 0; breq = 0;
        repeat (30) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
